ofdm_remove_cp: RTL

Receive-side counterpart of the transmit cyclic-prefix inserter. It takes a framed stream of SYMBOLS_SIZE+CP_LENGHT complex samples per OFDM symbol, discards the first CP_LENGHT samples and forwards the SYMBOLS_SIZE useful samples to the FFT. It sits between the timing-sync block, which supplies the symbol-start strobe, and the receive FFT. Streaming only, no sample storage; symbol framing is recovered by counters.

---
 rtl/ofdm_pkg.sv | 40 ++++
 rtl/ofdm_sym_counter.sv | 58 +++++
 rtl/ofdm_remove_cp.sv | 98 +++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// Shared types and helpers for the OFDM cyclic-prefix remover.
// Holds state encoding, counter width and symbol boundary helpers.
package ofdm_pkg;

   // Symbol position counter width.
   localparam int CNT_W = 16;

   typedef logic [CNT_W-1:0] pos_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SKIP_CP = 2'd1,
      PASS    = 2'd2
   } state_t;

   // Boundary decodes of the current position, all combinational.
   typedef struct packed {
      logic is_cp;
      logic is_first;
      logic is_last;
      logic cp_end;
      logic at_zero;
   } pos_flags_t;

   // First useful position: CP_BOUND = CP_LENGHT.
   function automatic pos_t cp_bound(
      input int cp
   );
      return pos_t'(cp);
   endfunction

   // Last position: LAST_POS = SYMBOLS_SIZE + CP_LENGHT - 1.
   function automatic pos_t last_pos(
      input int sym,
      input int cp
   );
      return pos_t'(sym + cp - 1);
   endfunction

endpackage

// File: rtl/ofdm_sym_counter.sv
// Position-within-symbol counter with boundary decodes.
// Ports: clk, reset (async low), restart (load CP sample 0),
//        step (advance one sample), flags (is_cp/first/last/...).
module ofdm_sym_counter
   import ofdm_pkg::*;
#(
   parameter int SYMBOLS_SIZE = 256,
   parameter int CP_LENGHT    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       restart,
   input  logic       step,
   output pos_flags_t flags
);

   localparam pos_t CP_BOUND =
      cp_bound(CP_LENGHT);
   localparam pos_t LAST_POS =
      last_pos(SYMBOLS_SIZE, CP_LENGHT);
   localparam pos_t CP_END =
      CP_BOUND - pos_t'(1);

   pos_t pos_q;
   pos_t pos_d;

   always_comb begin
      flags.is_cp    = (pos_q < CP_BOUND);
      flags.is_first = (pos_q == CP_BOUND);
      flags.is_last  = (pos_q == LAST_POS);
      flags.cp_end   = (pos_q == CP_END);
      flags.at_zero  = (pos_q == '0);
   end

   // The restarting sample is CP sample 0, so the
   // following one sits at position 1.
   always_comb begin
      pos_d = pos_q;
      unique case (1'b1)
         restart:
            pos_d = pos_t'(1);
         step && flags.is_last:
            pos_d = '0;
         step && !flags.is_last:
            pos_d = pos_q + pos_t'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end

endmodule

// File: rtl/ofdm_remove_cp.sv
// Receive-side cyclic-prefix remover: drops CP_LENGHT samples
// and forwards SYMBOLS_SIZE useful samples per OFDM symbol.
// Ports: clk, reset (async low), in_data_en/i/q, in_sym_start,
//        output_en, out_data_i/q, out_sym_start, out_sym_last,
//        sym_error (one-cycle early-start abort pulse).
module ofdm_remove_cp
   import ofdm_pkg::*;
#(
   parameter int DATA_SIZE    = 16,
   parameter int SYMBOLS_SIZE = 256,
   parameter int CP_LENGHT    = 8,
   parameter int CONTINUOUS   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_data_en,
   input  logic [DATA_SIZE-1:0] in_data_i,
   input  logic [DATA_SIZE-1:0] in_data_q,
   input  logic                 in_sym_start,
   output logic                 output_en,
   output logic [DATA_SIZE-1:0] out_data_i,
   output logic [DATA_SIZE-1:0] out_data_q,
   output logic                 out_sym_start,
   output logic                 out_sym_last,
   output logic                 sym_error
);

   // With a one-sample prefix the start sample already
   // completes the CP, so forwarding begins right after it.
   localparam state_t START_NEXT =
      (CP_LENGHT == 1) ? PASS : SKIP_CP;
   localparam state_t WRAP_NEXT =
      (CONTINUOUS != 0) ? SKIP_CP : IDLE;

   state_t     state;
   pos_flags_t flags;
   logic       restart;
   logic       step;

   assign restart = in_data_en & in_sym_start;
   assign step    = in_data_en & ~in_sym_start
                  & (state != IDLE);

   ofdm_sym_counter #(
      .SYMBOLS_SIZE (SYMBOLS_SIZE),
      .CP_LENGHT    (CP_LENGHT)
   ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .step    (step),
      .flags   (flags)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         output_en     <= 1'b0;
         out_data_i    <= '0;
         out_data_q    <= '0;
         out_sym_start <= 1'b0;
         out_sym_last  <= 1'b0;
         sym_error     <= 1'b0;
      end else begin
         output_en     <= 1'b0;
         out_sym_start <= 1'b0;
         out_sym_last  <= 1'b0;
         sym_error     <= 1'b0;
         if (restart) begin
            // Position 0 is a legal boundary; anything
            // else means the current symbol is cut short.
            sym_error <= (state != IDLE)
                       && !flags.at_zero;
            state     <= START_NEXT;
         end else if (step) begin
            unique case (state)
               SKIP_CP: begin
                  if (flags.cp_end)
                     state <= PASS;
               end
               PASS: begin
                  if (!flags.is_cp) begin
                     output_en     <= 1'b1;
                     out_data_i    <= in_data_i;
                     out_data_q    <= in_data_q;
                     out_sym_start <= flags.is_first;
                     out_sym_last  <= flags.is_last;
                  end
                  if (flags.is_last)
                     state <= WRAP_NEXT;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
